dm_arbiter: RTL

- Sequences and shares the single data-memory (DM) port between two requesters:
  - the pipeline M stage (CPU port);
  - an external master (EXT port: debug loader or DMA bridge).
- Registers one access at a time and holds it for a configurable number of wait states.
- Returns read data with a one-cycle done pulse.
- Drives the stall the hazard unit uses to freeze the pipeline while the CPU access is pending.

---
 rtl/dm_arb_defs.sv | 33 +++
 rtl/dm_arb_rr.sv | 28 ++
 rtl/dm_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dm_arb_defs.sv
// dm_arb_defs: state/owner encodings and the latched request bundle
// shared by dm_arb_rr and dm_arbiter.
package dm_arb_defs;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_EXT = 1'b1
   } owner_t;

   // One DM access as captured at grant time.
   // Only the word address is kept; the DM port is word-aligned.
   typedef struct packed {
      logic        we;
      logic [29:0] word;
      logic [31:0] wdata;
      logic [3:0]  be;
   } dm_req_t;

   localparam dm_req_t REQ_CLEAR = '0;

   function automatic logic word_in_range(
      input logic [29:0] word,
      input int unsigned words
   );
      return {2'b00, word} < words;
   endfunction

endpackage

// File: rtl/dm_arb_rr.sv
// dm_arb_rr: 2-way round-robin pick between CPU and EXT.
// Ports: req_cpu/req_ext requests, last_owner history in; grant/winner out.
module dm_arb_rr
   import dm_arb_defs::*;
(
   input  logic   req_cpu,
   input  logic   req_ext,
   input  owner_t last_owner,
   output logic   grant,
   output owner_t winner
);

   assign grant = req_cpu | req_ext;

   // On a tie the side that did not own the previous access wins.
   always_comb begin
      winner = OWN_CPU;
      unique case (1'b1)
         (req_cpu & req_ext):
            winner = (last_owner == OWN_CPU) ? OWN_EXT : OWN_CPU;
         (~req_cpu & req_ext):
            winner = OWN_EXT;
         default:
            winner = OWN_CPU;
      endcase
   end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between the CPU M stage
// and an external master, one access at a time with LATENCY wait states.
// Ports: clk, reset (async, active-low); cpu_* and ext_* request ports
// (req/we/addr/wdata/be in, rdata/done out, cpu_stall out); dm_* memory port.
// Optional DM_ARBITER_PERF_EN adds conflict_cnt and ext_wait_cnt outputs.
module dm_arbiter
   import dm_arb_defs::*;
#(
   parameter int unsigned LATENCY  = 2,
   parameter int unsigned DM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_be,
   output logic [31:0] cpu_rdata,
   output logic        cpu_done,
   output logic        cpu_stall,
   input  logic        ext_req,
   input  logic        ext_we,
   input  logic [31:0] ext_addr,
   input  logic [31:0] ext_wdata,
   input  logic [3:0]  ext_be,
   output logic [31:0] ext_rdata,
   output logic        ext_done,
   output logic        dm_en,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_be,
   input  logic [31:0] dm_rdata
`ifdef DM_ARBITER_PERF_EN
   ,
   output logic [31:0] conflict_cnt,
   output logic [31:0] ext_wait_cnt
`endif
);

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t     state;
   owner_t     owner;
   owner_t     last_owner;
   logic [3:0] cnt;
   dm_req_t    lat;

   logic       grant;
   owner_t     winner;
   dm_req_t    cpu_pl;
   dm_req_t    ext_pl;
   dm_req_t    win_pl;
   logic       in_range;
   logic       last_beat;
   logic       unused_addr_lsb;

   assign unused_addr_lsb = ^{cpu_addr[1:0], ext_addr[1:0]};

   assign cpu_pl = '{
      we:    cpu_we,
      word:  cpu_addr[31:2],
      wdata: cpu_wdata,
      be:    cpu_be
   };

   assign ext_pl = '{
      we:    ext_we,
      word:  ext_addr[31:2],
      wdata: ext_wdata,
      be:    ext_be
   };

   dm_arb_rr u_rr (
      .req_cpu    (cpu_req),
      .req_ext    (ext_req),
      .last_owner (last_owner),
      .grant      (grant),
      .winner     (winner)
   );

   assign win_pl    = (winner == OWN_EXT) ? ext_pl : cpu_pl;
   assign in_range  = word_in_range(lat.word, DM_WORDS);
   assign last_beat = (state == ST_BUSY) && (cnt == 4'd0);

   // Requests are only sampled in IDLE, so payload edits
   // made during BUSY never reach the DM port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         owner      <= OWN_CPU;
         last_owner <= OWN_EXT;
         cnt        <= 4'd0;
         lat        <= REQ_CLEAR;
         cpu_rdata  <= 32'd0;
         ext_rdata  <= 32'd0;
         cpu_done   <= 1'b0;
         ext_done   <= 1'b0;
      end else begin
         cpu_done <= 1'b0;
         ext_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (grant) begin
                  owner <= winner;
                  lat   <= win_pl;
                  cnt   <= CNT_INIT;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (owner == OWN_CPU) begin
                     cpu_rdata <= in_range ? dm_rdata : 32'd0;
                     cpu_done  <= 1'b1;
                  end else begin
                     ext_rdata <= in_range ? dm_rdata : 32'd0;
                     ext_done  <= 1'b1;
                  end
                  last_owner <= owner;
                  state      <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign dm_en    = (state == ST_BUSY);
   assign dm_we    = last_beat & lat.we & in_range;
   assign dm_addr  = {lat.word, 2'b00};
   assign dm_wdata = lat.wdata;
   assign dm_be    = dm_en ? lat.be : 4'b0000;

   assign cpu_stall = cpu_req & ~cpu_done;

`ifdef DM_ARBITER_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         conflict_cnt <= 32'd0;
         ext_wait_cnt <= 32'd0;
      end else begin
         if ((state == ST_IDLE) && cpu_req && ext_req &&
             (conflict_cnt != 32'hFFFF_FFFF))
            conflict_cnt <= conflict_cnt + 32'd1;
         if (ext_req && !ext_done &&
             (ext_wait_cnt != 32'hFFFF_FFFF))
            ext_wait_cnt <= ext_wait_cnt + 32'd1;
      end
   end
`endif

endmodule
